fx2_wr_sched: RTL
=================

// Module: fx2_wr_sched
// PURPOSE
//  Write scheduler for the FX2 slave-FIFO port in the ifclk domain. Shares the 16-bit FD bus
//  between two word streams (A: capture FIFO read side, B: status/marker words) using
//  per-word round-robin. Drives SLWR/FD and commits short packets with PKTEND on idle
//  timeout or on an explicit flush request.
// PARAMETERS
//  PKT_WORDS  256   words per full FX2 packet (FX2 auto-commits at this count); >=2
//  TIMEOUT    4096  idle cycles with a partial packet before PKTEND is issued; >=2
// PORTS
//  clk_i      in   1   ifclk; the only clock
//  reset_ni   in   1   synchronous, active-low reset
//  a_data_i   in   16  stream A word
//  a_valid_i  in   1   stream A word available
//  a_ack_o    out  1   stream A word taken this cycle (combinational, pops source)
//  b_data_i   in   16  stream B word
//  b_valid_i  in   1   stream B word available
//  b_ack_o    out  1   stream B word taken this cycle (combinational)
//  full_ni    in   1   FX2 FLAGB; low = endpoint FIFO full
//  flush_i    in   1   request commit of the current partial packet (pulse or level)
//  slwr_o     out  1   FX2 write strobe, active high; word committed on edge where high
//  pktend_o   out  1   FX2 packet-end strobe, active high, one cycle
//  fd_o       out  16  FX2 data bus
//  busy_o     out  1   pending word held, or state != RUN
// BEHAVIOUR
//  Reset (reset_ni low at edge): state=RUN, pend_r=0, fd_o=0, cnt=0, timer=0,
//   last_r=B (A wins first tie). Pending word dropped; packet count is not preserved.
//   While reset_ni is low: slwr_o=0, pktend_o=0, acks=0.
//  Holding register: pend_r/data_r hold one word. slwr_o = pend_r & full_ni & (state==RUN).
//   fd_o = data_r (registered). commit = slwr_o.
//  Load: in RUN, if (!pend_r | commit) and a source is valid, grant one source.
//   Both valid -> source != last_r; else the valid one. Ack the granted source in the same
//   cycle; next edge: data_r <= word, pend_r <= 1, last_r <= winner.
//   Latency: ack -> slwr_o high 1 cycle later (when full_ni high). Back-to-back commit and
//   load sustains 1 word/cycle.
//  Full: full_ni low -> no commit; data_r held stable; no further ack until commit.
//  cnt (log2(PKT_WORDS) bits): +1 per commit; at PKT_WORDS-1 plus commit -> 0 (auto-commit,
//   no PKTEND).
//  timer: cleared on any commit or load, and whenever cnt==0. Otherwise +1 per cycle while
//   cnt!=0 and !pend_r; saturates at TIMEOUT-1.
//  FSM:
//   RUN  -> END when cnt!=0 & !pend_r & (timer==TIMEOUT-1 | flush_seen).
//           flush_seen is set by flush_i and cleared on entry to END or when cnt returns to 0.
//           flush with cnt==0 and no pend_r is discarded (no zero-length packets).
//           flush with pend_r set: the word commits first, then END.
//           No loads in the cycle the transition to END is taken.
//   END  -> pktend_o high one cycle when full_ni high; cnt<=0, timer<=0 -> GAP.
//           Waits in END while full_ni low. No acks, no slwr_o.
//   GAP  -> one dead cycle (FX2 PKTEND-to-SLWR spacing), no acks -> RUN.
//  Simultaneous: flush_i on the commit that wraps cnt to 0 -> no PKTEND; flush_seen
//   cleared. Timeout is never reached while a source is valid and space exists.
//  Stream data is never dropped or duplicated: every ack yields exactly one commit,
//   except for a word pending at reset.
// TESTING
//  1. A only, 600 words 0x0000.., full_ni=1 -> 600 slwr pulses in order, 1/cycle, no pktend
//     for the first 512; after TIMEOUT idle cycles, one pktend for the 88-word tail.
//  2. A and B valid continuously -> commits alternate A,B,A,B starting with A; each ack
//     matches the fd_o word one cycle later.
//  3. full_ni low for 10 cycles mid-stream -> slwr_o low, fd_o stable, acks stop; resumes
//     with the held word first, no loss.
//  4. Commit 5 words, pulse flush_i -> pktend_o one cycle after last commit + FSM delay, GAP
//     cycle with no slwr; flush with cnt==0 -> no pktend.
//  5. flush_i on the 256th commit (PKT_WORDS=256) -> cnt wraps to 0, no pktend.
//  6. reset_ni low for 1 cycle with a word pending and cnt=37 -> slwr_o/pktend_o=0 at once;
//     cnt=0; next A word acked goes out first.

Source files
------------

// File: rtl/fx2_wr_sched.sv
// rtl/fx2_wr_sched.sv - FX2 slave-FIFO write scheduler: round-robin of two word streams onto FD
// with one-word holding register, packet counting and PKTEND on idle timeout or flush.
module fx2_wr_sched #(
  parameter int PKT_WORDS = 256,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [15:0] a_data_i,
  input  logic        a_valid_i,
  output logic        a_ack_o,
  input  logic [15:0] b_data_i,
  input  logic        b_valid_i,
  output logic        b_ack_o,
  input  logic        full_ni,
  input  logic        flush_i,
  output logic        slwr_o,
  output logic        pktend_o,
  output logic [15:0] fd_o,
  output logic        busy_o
);

  localparam int CW = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_WORDS - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_END, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic          pend_r;
  logic [15:0]   data_r;
  logic [CW-1:0] cnt_r;
  logic [TW-1:0] timer_r;
  logic          last_b_r;
  logic          flush_seen_r;
  logic          go_end;
  logic          load;
  logic          cnt_zero;
  logic          wrap;

  assign cnt_zero = (cnt_r == '0);
  assign wrap     = slwr_o & (cnt_r == CNT_LAST);
  assign load     = a_ack_o | b_ack_o;
  assign fd_o     = data_r;
  assign busy_o   = pend_r | (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    a_ack_o  = 1'b0;
    b_ack_o  = 1'b0;
    slwr_o   = 1'b0;
    pktend_o = 1'b0;
    go_end   = 1'b0;
    case (state_q)
      ST_RUN: begin
        slwr_o = reset_ni & pend_r & full_ni;
        go_end = !cnt_zero & !pend_r & ((timer_r == TMR_LAST) | flush_seen_r);
        if (go_end) begin
          state_d = ST_END;
        end else if (reset_ni & (!pend_r | slwr_o)) begin
          // A wins unless B is also valid and A was the previous winner
          if (a_valid_i & (!b_valid_i | last_b_r)) a_ack_o = 1'b1;
          else if (b_valid_i)                      b_ack_o = 1'b1;
        end
      end
      ST_END: begin
        pktend_o = reset_ni & full_ni;
        if (full_ni) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= ST_RUN;
      pend_r       <= 1'b0;
      data_r       <= '0;
      cnt_r        <= '0;
      timer_r      <= '0;
      last_b_r     <= 1'b1;
      flush_seen_r <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load) begin
        data_r   <= a_ack_o ? a_data_i : b_data_i;
        last_b_r <= b_ack_o;
        pend_r   <= 1'b1;
      end else if (slwr_o) begin
        pend_r <= 1'b0;
      end

      if (pktend_o)    cnt_r <= '0;
      else if (wrap)   cnt_r <= '0;
      else if (slwr_o) cnt_r <= cnt_r + 1'b1;

      if (slwr_o | load | cnt_zero | pktend_o) timer_r <= '0;
      else if (!pend_r && timer_r != TMR_LAST) timer_r <= timer_r + 1'b1;

      // an empty packet never latches a flush, so no zero-length PKTEND
      if (go_end | wrap | (cnt_zero & !pend_r)) flush_seen_r <= 1'b0;
      else if (flush_i)                         flush_seen_r <= 1'b1;
    end
  end

endmodule
